run_detect_scheduler: RTL and testbench

- Shares one run-length detector datapath (N identical consecutive bits -> z) among NCH independent serial bit streams.
- Each stream gets a one-deep input slot and a private context (last bit, run length).
- A round-robin scheduler grants one pending stream per cycle to the shared update logic and reports a tagged detection result.
- Sits between board-level stream sources (switch/key sampling or test pattern generators) and LED/score logic.

---
 rtl/run_detect_pkg.sv | 32 +++
 rtl/run_detect_scheduler_rr_arbiter.sv | 33 +++
 rtl/run_detect_scheduler.sv | 119 +++++++++++
 tb/tb_run_detect_scheduler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/run_detect_pkg.sv
// Shared types for the run-length detector scheduler: per-stream context,
// one-deep input slot, and the run-length update rule.
package run_detect_pkg;

    // Run field is sized for the largest supported RUN_LEN so every build shares one type.
    localparam int RUN_LEN_MAX = 15;
    localparam int RUN_W       = $clog2(RUN_LEN_MAX + 1);

    typedef struct packed {
        logic             last;
        logic [RUN_W-1:0] run;
    } ctx_t;

    typedef struct packed {
        logic valid;
        logic data;
    } slot_t;

    function automatic ctx_t next_ctx(input ctx_t cur, input logic b,
                                      input logic [RUN_W-1:0] run_max);
        ctx_t nxt;
        nxt.last = b;
        if (cur.run == '0 || b != cur.last)
            nxt.run = RUN_W'(1);
        else if (cur.run < run_max)
            nxt.run = cur.run + RUN_W'(1);
        else
            nxt.run = cur.run;
        return nxt;
    endfunction

endpackage

// File: rtl/run_detect_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after i_ptr, wrapping
// modulo N, and returns both one-hot grant and encoded index.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W-1:0] w_cand;

    // Scan from the farthest offset down so the nearest request wins last.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int off = N - 1; off >= 0; off--) begin
            w_cand = IDX_W'((int'(i_ptr) + off) % N);
            if (i_req[w_cand]) begin
                o_grant         = '0;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
                o_any           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/run_detect_scheduler.sv
// NCH serial bit streams share one run-length detector; a round-robin
// scheduler feeds one pending bit per cycle and reports a tagged result.
module run_detect_scheduler
    import run_detect_pkg::*;
#(
    parameter  int NCH     = 4,
    parameter  int RUN_LEN = 4,
    parameter  int CNT_W   = 8,
    localparam int CH_W    = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       req,
    input  logic [NCH-1:0]       bit_in,
    input  logic [NCH-1:0]       chan_clr,
    output logic [NCH-1:0]       ack,
    output logic                 z_valid,
    output logic [CH_W-1:0]      z_ch,
    output logic                 z,
    output logic [NCH*CNT_W-1:0] hit_count,
    output logic [NCH-1:0]       overflow
);

    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN);
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NCH - 1);

    slot_t            w_slot [NCH];
    ctx_t             w_ctx  [NCH];
    logic [NCH-1:0]   w_pend;
    logic [NCH-1:0]   w_grant;
    logic [CH_W-1:0]  w_idx;
    logic             w_any;
    ctx_t             w_cur;
    ctx_t             w_next;
    logic             w_z;
    logic             w_new_hit;

    logic [CH_W-1:0]  r_ptr;
    logic             r_z_valid;
    logic [CH_W-1:0]  r_z_ch;
    logic             r_z;

    rr_arbiter #(.N(NCH), .IDX_W(CH_W)) u_arb (
        .i_req   (w_pend),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign ack       = w_grant;
    assign w_cur     = w_ctx[w_idx];
    assign w_next    = next_ctx(w_cur, w_slot[w_idx].data, RUN_MAX);
    assign w_z       = (w_next.run == RUN_MAX);
    assign w_new_hit = w_z && (w_cur.run != RUN_MAX);

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            slot_t            r_slot;
            ctx_t             r_ctx;
            logic [CNT_W-1:0] r_hit;
            logic             r_ovf;

            // A clear hides the slot from the arbiter in the same cycle.
            assign w_pend[gi] = r_slot.valid & ~chan_clr[gi];
            assign w_slot[gi] = r_slot;
            assign w_ctx[gi]  = r_ctx;
            assign hit_count[gi*CNT_W +: CNT_W] = r_hit;
            assign overflow[gi] = r_ovf;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_slot <= '0;
                    r_ctx  <= '0;
                    r_hit  <= '0;
                    r_ovf  <= 1'b0;
                end else begin
                    if (chan_clr[gi]) begin
                        r_slot <= '0;
                        r_ctx  <= '0;
                    end else begin
                        if (req[gi] && (!r_slot.valid || w_grant[gi]))
                            r_slot <= '{valid: 1'b1, data: bit_in[gi]};
                        else if (w_grant[gi])
                            r_slot.valid <= 1'b0;
                        if (req[gi] && r_slot.valid && !w_grant[gi])
                            r_ovf <= 1'b1;
                        if (w_grant[gi])
                            r_ctx <= w_next;
                    end
                    if (w_grant[gi] && w_new_hit && r_hit != '1)
                        r_hit <= r_hit + CNT_W'(1);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr     <= '0;
            r_z_valid <= 1'b0;
            r_z_ch    <= '0;
            r_z       <= 1'b0;
        end else begin
            r_z_valid <= w_any;
            if (w_any) begin
                r_z_ch <= w_idx;
                r_z    <= w_z;
                r_ptr  <= (w_idx == LAST_CH) ? '0 : w_idx + CH_W'(1);
            end
        end
    end

    assign z_valid = r_z_valid;
    assign z_ch    = r_z_ch;
    assign z       = r_z;

endmodule

// File: tb/tb_run_detect_scheduler.sv
// Directed bench for run_detect_scheduler: hand-computed results for
// round-robin ordering, run detection, overflow, channel clear and reset.
module tb_run_detect_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  bit_in = '0;
    logic [3:0]  chan_clr = '0;
    logic [3:0]  ack;
    logic        z_valid;
    logic [1:0]  z_ch;
    logic        z;
    logic [31:0] hit_count;
    logic [3:0]  overflow;

    int checks = 0;
    int failures = 0;

    run_detect_scheduler #(.NCH(4), .RUN_LEN(4), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .bit_in    (bit_in),
        .chan_clr  (chan_clr),
        .ack       (ack),
        .z_valid   (z_valid),
        .z_ch      (z_ch),
        .z         (z),
        .hit_count (hit_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] hit_of(input int ch);
        return hit_count[ch*8 +: 8];
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        req = '0;
        bit_in = '0;
        chan_clr = '0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    // One isolated bit: ack one cycle after req, result the cycle after that.
    task automatic send_one(input int ch, input logic b, input logic exp_z, input string tag);
        req[ch] = 1'b1;
        bit_in[ch] = b;
        step();
        req[ch] = 1'b0;
        check_eq({tag, ".ack"}, 32'(ack), 32'(1) << ch);
        step();
        check_eq({tag, ".z_valid"}, 32'(z_valid), 32'd1);
        check_eq({tag, ".z_ch"}, 32'(z_ch), 32'(ch));
        check_eq({tag, ".z"}, 32'(z), 32'(exp_z));
        $display("txn %s ch=%0d bit=%0d z_valid=%0d z_ch=%0d z=%0d", tag, ch, b, z_valid, z_ch, z);
        step();
        check_eq({tag, ".idle"}, 32'(z_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] t5_bits;
        logic [7:0] t5_z;

        // Reset values
        step();
        step();
        check_eq("rst.ack", 32'(ack), 32'd0);
        check_eq("rst.z_valid", 32'(z_valid), 32'd0);
        check_eq("rst.z_ch", 32'(z_ch), 32'd0);
        check_eq("rst.z", 32'(z), 32'd0);
        check_eq("rst.hit", hit_count, 32'd0);
        check_eq("rst.ovf", 32'(overflow), 32'd0);
        reset = 1'b1;
        step();

        // ch0: five zeros -> z = 0,0,0,1,1 ; one new detection
        send_one(0, 1'b0, 1'b0, "t1_b0");
        send_one(0, 1'b0, 1'b0, "t1_b1");
        send_one(0, 1'b0, 1'b0, "t1_b2");
        send_one(0, 1'b0, 1'b1, "t1_b3");
        send_one(0, 1'b0, 1'b1, "t1_b4");
        check_eq("t1.hit0", 32'(hit_of(0)), 32'd1);

        // All four channels at once from pointer 0
        do_reset();
        req = 4'b1111;
        bit_in = 4'b1111;
        step();
        req = '0;
        check_eq("t2.ack0", 32'(ack), 32'b0001);
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("t2.z_valid", 32'(z_valid), 32'd1);
            check_eq("t2.z_ch", 32'(z_ch), 32'(k));
            check_eq("t2.z", 32'(z), 32'd0);
            check_eq("t2.ack", 32'(ack), (k < 3) ? (32'(1) << (k + 1)) : 32'd0);
            $display("txn t2 grant ch=%0d z_valid=%0d z_ch=%0d z=%0d", k, z_valid, z_ch, z);
        end
        step();
        check_eq("t2.idle", 32'(z_valid), 32'd0);
        // Pointer back at 0: ch0 must beat ch3
        req = 4'b1001;
        bit_in = 4'b1001;
        step();
        req = '0;
        check_eq("t2.ptr_ack", 32'(ack), 32'b0001);
        step();
        check_eq("t2.ptr_zch0", 32'(z_ch), 32'd0);
        check_eq("t2.ptr_ack3", 32'(ack), 32'b1000);
        step();
        check_eq("t2.ptr_zch3", 32'(z_ch), 32'd3);
        step();

        // Overflow on ch2 while ch0/ch1 are pending
        do_reset();
        req = 4'b0111;
        bit_in = 4'b0000;
        step();
        req = 4'b0100;
        step();
        req = '0;
        check_eq("t3.ovf", 32'(overflow), 32'b0100);
        check_eq("t3.zch0", 32'(z_ch), 32'd0);
        step();
        check_eq("t3.zch1", 32'(z_ch), 32'd1);
        step();
        check_eq("t3.zch2", 32'(z_ch), 32'd2);
        $display("txn t3 ch2 result z_valid=%0d z_ch=%0d overflow=%b", z_valid, z_ch, overflow);
        step();
        check_eq("t3.dropped", 32'(z_valid), 32'd0);
        check_eq("t3.ovf_sticky", 32'(overflow), 32'b0100);
        // Refill of a slot granted in the same cycle is not an overflow
        req = 4'b0010;
        bit_in = 4'b0010;
        step();
        check_eq("t3.refill_ack", 32'(ack), 32'b0010);
        step();
        req = '0;
        check_eq("t3.refill_z1", 32'(z_valid), 32'd1);
        check_eq("t3.refill_ack2", 32'(ack), 32'b0010);
        step();
        check_eq("t3.refill_z2", 32'(z_valid), 32'd1);
        check_eq("t3.refill_zch", 32'(z_ch), 32'd1);
        check_eq("t3.refill_ovf", 32'(overflow), 32'b0100);
        step();

        // ch1: 1,1,1 then a pending 1 is cleared; the next 1 restarts the run
        do_reset();
        send_one(1, 1'b1, 1'b0, "t4_b0");
        send_one(1, 1'b1, 1'b0, "t4_b1");
        send_one(1, 1'b1, 1'b0, "t4_b2");
        req[1] = 1'b1;
        bit_in[1] = 1'b1;
        step();
        req = '0;
        check_eq("t4.pend_ack", 32'(ack), 32'b0010);
        chan_clr[1] = 1'b1;
        #1;
        check_eq("t4.clr_ack", 32'(ack), 32'd0);
        step();
        chan_clr = '0;
        check_eq("t4.clr_noz", 32'(z_valid), 32'd0);
        step();
        check_eq("t4.clr_noz2", 32'(z_valid), 32'd0);
        send_one(1, 1'b1, 1'b0, "t4_restart");
        check_eq("t4.hit1", 32'(hit_of(1)), 32'd0);

        // ch3: 1,1,1,1,0,0,0,0 -> detections on 4th and 8th bit
        do_reset();
        t5_bits = 8'b0000_1111;
        t5_z    = 8'b1000_1000;
        for (int i = 0; i < 8; i++)
            send_one(3, t5_bits[i], t5_z[i], $sformatf("t5_b%0d", i));
        check_eq("t5.hit3", 32'(hit_of(3)), 32'd2);

        // Reset with three slots pending clears everything and yields no results
        req = 4'b0111;
        bit_in = 4'b0111;
        step();
        req = '0;
        check_eq("t6.pend_ack", 32'(ack), 32'b0001);
        reset = 1'b0;
        step();
        check_eq("t6.z_valid", 32'(z_valid), 32'd0);
        check_eq("t6.ack", 32'(ack), 32'd0);
        check_eq("t6.z_ch", 32'(z_ch), 32'd0);
        check_eq("t6.z", 32'(z), 32'd0);
        check_eq("t6.hit", hit_count, 32'd0);
        check_eq("t6.ovf", 32'(overflow), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("t6.quiet", 32'(z_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
